// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory-busy freeze, branch flush
// (held pending across a freeze), operand forwarding and saturating perf counters.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rn,
  input  logic [REG_ADDR_W-1:0] ex_rm,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  id_ex_enable,
  output logic                  ex_mem_enable,
  output logic                  mem_wb_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FREEZE     = 2'd1,
    FLUSH_PEND = 2'd2
  } state_t;

  // R15 is the PC, never a forwarding source.
  localparam logic [REG_ADDR_W-1:0] NO_FWD_REG = '1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] stall_count_reg, flush_count_reg;
  logic             stall_inc, flush_inc;
  logic             flush_now, load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  m_we,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic                  w_we
  );
    if (m_we && (m_rd == src) && (m_rd != NO_FWD_REG))
      return 2'b10;
    else if (w_we && (w_rd == src) && (w_rd != NO_FWD_REG))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // FLUSH_PEND doubles as the pending-branch bit.
  assign flush_now = !mem_busy && (branch_taken || (state_reg == FLUSH_PEND));
  assign load_use  = ex_mem_to_reg && ex_reg_write &&
                     ((id_uses_rn && (ex_rd == id_rn)) ||
                      (id_uses_rm && (ex_rd == id_rm)));

  always_comb begin
    state_next    = state_reg;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    forward_a     = 2'b00;
    forward_b     = 2'b00;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    if (!reset) begin
      state_next = RUN;
    end else begin
      forward_a = fwd_sel(ex_rn, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
      forward_b = fwd_sel(ex_rm, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
      if (mem_busy) begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_enable = 1'b0;
        stall_inc     = 1'b1;
        state_next    = (branch_taken || (state_reg == FLUSH_PEND)) ? FLUSH_PEND : FREEZE;
      end else if (flush_now) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc   = 1'b1;
        state_next  = RUN;
      end else begin
        state_next = RUN;
        if (load_use) begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_flush  = 1'b1;
          stall_inc    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= RUN;
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (stall_inc && !(&stall_count_reg))
        stall_count_reg <= stall_count_reg + 1'b1;
      if (flush_inc && !(&flush_count_reg))
        flush_count_reg <= flush_count_reg + 1'b1;
    end
  end

  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: driver pushes expected responses into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic [3:0] id_rn, id_rm;
    logic       uses_rn, uses_rm;
    logic [3:0] ex_rd;
    logic       ex_m2r, ex_rw;
    logic [3:0] ex_rn, ex_rm;
    logic [3:0] mem_rd;
    logic       mem_rw;
    logic [3:0] wb_rd;
    logic       wb_rw;
    logic       br, busy;
  } in_t;

  typedef struct packed {
    logic [15:0] idx;
    logic [4:0]  en;
    logic [1:0]  fl;
    logic [1:0]  fa, fb;
    logic [3:0]  sc, fc;
  } exp_t;

  localparam in_t IDLE = '{rst_n: 1'b1, default: '0};

  logic clk = 1'b0;
  in_t  vin = IDLE;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_n  = 0;

  logic pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
  logic if_id_flush, id_ex_flush;
  logic [1:0] forward_a, forward_b;
  logic [3:0] stall_count, flush_count;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(vin.rst_n),
    .id_rn(vin.id_rn), .id_rm(vin.id_rm),
    .id_uses_rn(vin.uses_rn), .id_uses_rm(vin.uses_rm),
    .ex_rd(vin.ex_rd), .ex_mem_to_reg(vin.ex_m2r), .ex_reg_write(vin.ex_rw),
    .ex_rn(vin.ex_rn), .ex_rm(vin.ex_rm),
    .mem_rd(vin.mem_rd), .mem_reg_write(vin.mem_rw),
    .wb_rd(vin.wb_rd), .wb_reg_write(vin.wb_rw),
    .branch_taken(vin.br), .mem_busy(vin.busy),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
    .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL vec %0d %s: got %b want %b", idx, nm, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle once a vector is applied.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        $display("vec %0d en=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d", e.idx,
                 {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable},
                 {if_id_flush, id_ex_flush}, forward_a, forward_b, stall_count, flush_count);
        chk("enables", int'(e.idx),
            {3'b0, pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable}, {3'b0, e.en});
        chk("flushes", int'(e.idx), {6'b0, if_id_flush, id_ex_flush}, {6'b0, e.fl});
        chk("forward_a", int'(e.idx), {6'b0, forward_a}, {6'b0, e.fa});
        chk("forward_b", int'(e.idx), {6'b0, forward_b}, {6'b0, e.fb});
        chk("stall_count", int'(e.idx), {4'b0, stall_count}, {4'b0, e.sc});
        chk("flush_count", int'(e.idx), {4'b0, flush_count}, {4'b0, e.fc});
      end
    end
  end

  // Apply current vin for one cycle and queue its expected response.
  task automatic step(input logic [4:0] en, input logic [1:0] fl, input logic [1:0] fa,
                      input logic [1:0] fb, input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    e.idx = 16'(vec_n);
    e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.sc = sc; e.fc = fc;
    q.push_back(e);
    vec_n++;
    @(posedge clk);
    #1;
    vin = IDLE;
  endtask

  task automatic set_load_use_rn();
    vin.ex_m2r = 1'b1; vin.ex_rw = 1'b1; vin.ex_rd = 4'd3;
    vin.id_rn = 4'd3; vin.uses_rn = 1'b1;
  endtask

  initial begin
    vin = IDLE;
    vin.rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vin = IDLE;

    // Reset dominates busy/branch; outputs forced to defaults.
    vin.rst_n = 1'b0; vin.busy = 1'b1; vin.br = 1'b1; vin.mem_rw = 1'b1;
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0);
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0);

    // Load-use on rn, bubble cycle, unused source, rm match, non-writing load.
    set_load_use_rn();
    step(5'b00111, 2'b01, 2'b00, 2'b00, 4'd0, 4'd0);
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd1, 4'd0);
    set_load_use_rn(); vin.uses_rn = 1'b0;
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd1, 4'd0);
    vin.ex_m2r = 1'b1; vin.ex_rw = 1'b1; vin.ex_rd = 4'd3; vin.id_rm = 4'd3; vin.uses_rm = 1'b1;
    step(5'b00111, 2'b01, 2'b00, 2'b00, 4'd1, 4'd0);
    set_load_use_rn(); vin.ex_rw = 1'b0;
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd2, 4'd0);

    // Forwarding priority and R15 exclusion.
    vin.ex_rn = 4'd5; vin.mem_rd = 4'd5; vin.wb_rd = 4'd5; vin.mem_rw = 1'b1; vin.wb_rw = 1'b1;
    step(5'b11111, 2'b00, 2'b10, 2'b00, 4'd2, 4'd0);
    vin.ex_rn = 4'd5; vin.mem_rd = 4'd5; vin.wb_rd = 4'd5; vin.mem_rw = 1'b0; vin.wb_rw = 1'b1;
    step(5'b11111, 2'b00, 2'b01, 2'b00, 4'd2, 4'd0);
    vin.ex_rn = 4'd15; vin.mem_rd = 4'd15; vin.wb_rd = 4'd15; vin.mem_rw = 1'b1; vin.wb_rw = 1'b1;
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd2, 4'd0);
    vin.ex_rn = 4'd2; vin.ex_rm = 4'd7; vin.mem_rd = 4'd7; vin.wb_rd = 4'd7; vin.mem_rw = 1'b1; vin.wb_rw = 1'b1;
    step(5'b11111, 2'b00, 2'b00, 2'b10, 4'd2, 4'd0);
    vin.ex_rn = 4'd9; vin.ex_rm = 4'd9; vin.mem_rd = 4'd9; vin.wb_rd = 4'd9; vin.wb_rw = 1'b1;
    step(5'b11111, 2'b00, 2'b01, 2'b01, 4'd2, 4'd0);

    // Freeze 3 cycles with branch in the 2nd; forwarding stays live.
    vin.busy = 1'b1; vin.ex_rn = 4'd4; vin.mem_rd = 4'd4; vin.mem_rw = 1'b1;
    step(5'b00000, 2'b00, 2'b10, 2'b00, 4'd2, 4'd0);
    vin.busy = 1'b1; vin.br = 1'b1;
    step(5'b00000, 2'b00, 2'b00, 2'b00, 4'd3, 4'd0);
    vin.busy = 1'b1;
    step(5'b00000, 2'b00, 2'b00, 2'b00, 4'd4, 4'd0);
    step(5'b11111, 2'b11, 2'b00, 2'b00, 4'd5, 4'd0);
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd5, 4'd1);

    // Freeze exit evaluates load-use in the same cycle.
    vin.busy = 1'b1;
    step(5'b00000, 2'b00, 2'b00, 2'b00, 4'd5, 4'd1);
    set_load_use_rn();
    step(5'b00111, 2'b01, 2'b00, 2'b00, 4'd6, 4'd1);

    // Branch beats load-use.
    set_load_use_rn(); vin.br = 1'b1;
    step(5'b11111, 2'b11, 2'b00, 2'b00, 4'd7, 4'd1);
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd7, 4'd2);

    // Pending branch plus new pulse counts as a single flush.
    vin.busy = 1'b1; vin.br = 1'b1;
    step(5'b00000, 2'b00, 2'b00, 2'b00, 4'd7, 4'd2);
    vin.br = 1'b1;
    step(5'b11111, 2'b11, 2'b00, 2'b00, 4'd8, 4'd2);
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd8, 4'd3);

    // Reset while pending discards the flush.
    vin.busy = 1'b1; vin.br = 1'b1;
    step(5'b00000, 2'b00, 2'b00, 2'b00, 4'd8, 4'd3);
    vin.rst_n = 1'b0;
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd9, 4'd3);
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0);

    // Saturation of the 4-bit stall counter.
    for (int i = 0; i < 20; i++) begin
      vin.busy = 1'b1;
      step(5'b00000, 2'b00, 2'b00, 2'b00, (i > 15) ? 4'd15 : 4'(i), 4'd0);
    end
    set_load_use_rn();
    step(5'b00111, 2'b01, 2'b00, 2'b00, 4'd15, 4'd0);
    step(5'b11111, 2'b00, 2'b00, 2'b00, 4'd15, 4'd0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
